// File: rtl/vend_pkg.sv
// Shared definitions for the vending payout path: FSM states, change width,
// coin values and a saturating debit helper.
package vend_pkg;

    localparam int AMT_W        = 4;
    localparam int TMR_W        = 8;
    localparam int DFLT_BIG_VAL = 5;
    localparam int SMALL_VAL    = 1;

    typedef logic [AMT_W-1:0] amount_t;
    typedef logic [TMR_W-1:0] tmr_t;

    typedef enum logic [2:0] {
        IDLE,
        PULSE,
        WAIT_ACK,
        GAP,
        FAULT
    } disp_state_e;

    // Subtract a coin value from the owed change, clamping at zero so the
    // display can never wrap around.
    function automatic amount_t debit(input amount_t remain, input amount_t value);
        return (remain >= value) ? amount_t'(remain - value) : '0;
    endfunction

endpackage

// File: rtl/change_dispenser_if.sv
// Request/hopper/display bundle between the payment logic and the change
// dispenser. The master side requests payouts and models the hopper ack.
interface change_dispenser_if;
    import vend_pkg::*;

    logic    req;
    amount_t amount;
    logic    coin_ack;
    logic    fault_clr;
    logic    coin_big;
    logic    coin_small;
    logic    busy;
    logic    done;
    logic    fault;
    amount_t remain;

    modport master (
        output req, amount, coin_ack, fault_clr,
        input  coin_big, coin_small, busy, done, fault, remain
    );

    modport slave (
        input  req, amount, coin_ack, fault_clr,
        output coin_big, coin_small, busy, done, fault, remain
    );

endinterface

// File: rtl/cycle_timer.sv
// Loadable 8-bit down-counter with a zero flag. It stops at zero, so a
// load of N-1 gives a zero flag after exactly N-1 further cycles.
module cycle_timer
    import vend_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic i_load,
    input  tmr_t i_load_val,
    output logic o_zero
);

    tmr_t r_count;

    // Load takes priority; otherwise count down and hold at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (r_count != '0) begin
            r_count <= r_count - tmr_t'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/change_dispenser.sv
// Pays out owed change one coin at a time on a two-denomination hopper:
// greedy coin choice, fixed-width select pulse, edge-detected acknowledge,
// inter-coin gap, and a jam fault when the hopper never answers.
module change_dispenser
    import vend_pkg::*;
#(
    parameter int PULSE_CYC   = 4,
    parameter int GAP_CYC     = 4,
    parameter int ACK_TIMEOUT = 200,
    parameter int BIG_VAL     = DFLT_BIG_VAL
) (
    input  logic              clk,
    input  logic              rst_n,
    change_dispenser_if.slave bus
);

    localparam amount_t BIG_AMT    = amount_t'(BIG_VAL);
    localparam amount_t SMALL_AMT  = amount_t'(SMALL_VAL);
    localparam tmr_t    PULSE_LOAD = tmr_t'(PULSE_CYC - 1);
    localparam tmr_t    GAP_LOAD   = tmr_t'(GAP_CYC - 1);
    localparam tmr_t    ACK_LOAD   = tmr_t'(ACK_TIMEOUT - 1);

    disp_state_e r_state;
    disp_state_e w_state_next;
    amount_t     r_remain;
    amount_t     w_remain_next;
    logic        r_coin_big;
    logic        w_coin_big_next;
    logic        r_coin_small;
    logic        w_coin_small_next;
    logic        r_busy;
    logic        w_busy_next;
    logic        r_done;
    logic        w_done_next;
    logic        r_fault;
    logic        w_fault_next;
    logic        r_denom_big;
    logic        w_denom_big_next;
    logic        r_ack_prev;
    logic        r_ack_latched;
    logic        w_ack_latched_next;

    logic        w_ack_rise;
    logic        w_ack_seen;
    logic        w_tmr_load;
    tmr_t        w_tmr_val;
    logic        w_tmr_zero;
    amount_t     w_coin_val;

    // The hopper may hold ack for several cycles or across coins, so only a
    // rising edge counts as one coin ejected.
    assign w_ack_rise = bus.coin_ack & ~r_ack_prev;
    assign w_ack_seen = r_ack_latched | w_ack_rise;
    assign w_coin_val = r_denom_big ? BIG_AMT : SMALL_AMT;

    cycle_timer u_timer (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_zero     (w_tmr_zero)
    );

    // Next state and next registered outputs; the shared timer is reloaded
    // on every entry into a timed state.
    always_comb begin
        w_state_next       = r_state;
        w_remain_next      = r_remain;
        w_coin_big_next    = 1'b0;
        w_coin_small_next  = 1'b0;
        w_done_next        = 1'b0;
        w_denom_big_next   = r_denom_big;
        w_ack_latched_next = r_ack_latched;
        w_tmr_load         = 1'b0;
        w_tmr_val          = '0;

        case (r_state)
            IDLE: begin
                w_ack_latched_next = 1'b0;
                if (bus.req) begin
                    w_remain_next = bus.amount;
                    if (bus.amount == '0) begin
                        w_done_next = 1'b1;
                    end else begin
                        w_state_next      = PULSE;
                        w_denom_big_next  = (bus.amount >= BIG_AMT);
                        w_coin_big_next   = (bus.amount >= BIG_AMT);
                        w_coin_small_next = (bus.amount < BIG_AMT);
                        w_tmr_load        = 1'b1;
                        w_tmr_val         = PULSE_LOAD;
                    end
                end
            end

            PULSE: begin
                // An ack arriving early is remembered for WAIT_ACK.
                if (w_ack_rise) begin
                    w_ack_latched_next = 1'b1;
                end
                if (w_tmr_zero) begin
                    w_state_next = WAIT_ACK;
                    w_tmr_load   = 1'b1;
                    w_tmr_val    = ACK_LOAD;
                end else begin
                    w_coin_big_next   = r_coin_big;
                    w_coin_small_next = r_coin_small;
                end
            end

            WAIT_ACK: begin
                if (w_ack_seen) begin
                    w_remain_next      = debit(r_remain, w_coin_val);
                    w_ack_latched_next = 1'b0;
                    w_state_next       = GAP;
                    w_tmr_load         = 1'b1;
                    w_tmr_val          = GAP_LOAD;
                end else if (w_tmr_zero) begin
                    w_state_next = FAULT;
                end
            end

            GAP: begin
                if (w_tmr_zero) begin
                    if (r_remain == '0) begin
                        w_state_next = IDLE;
                        w_done_next  = 1'b1;
                    end else begin
                        w_state_next      = PULSE;
                        w_denom_big_next  = (r_remain >= BIG_AMT);
                        w_coin_big_next   = (r_remain >= BIG_AMT);
                        w_coin_small_next = (r_remain < BIG_AMT);
                        w_tmr_load        = 1'b1;
                        w_tmr_val         = PULSE_LOAD;
                    end
                end
            end

            FAULT: begin
                // remain stays frozen so the display shows the unpaid change.
                w_ack_latched_next = 1'b0;
                if (bus.fault_clr) begin
                    w_state_next  = IDLE;
                    w_remain_next = '0;
                end
            end

            default: begin
                w_state_next = IDLE;
            end
        endcase

        w_busy_next  = (w_state_next != IDLE);
        w_fault_next = (w_state_next == FAULT);
    end

    // State and all outputs are registered; reset drops the coin lines at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= IDLE;
            r_remain      <= '0;
            r_coin_big    <= 1'b0;
            r_coin_small  <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_fault       <= 1'b0;
            r_denom_big   <= 1'b0;
            r_ack_prev    <= 1'b0;
            r_ack_latched <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_remain      <= w_remain_next;
            r_coin_big    <= w_coin_big_next;
            r_coin_small  <= w_coin_small_next;
            r_busy        <= w_busy_next;
            r_done        <= w_done_next;
            r_fault       <= w_fault_next;
            r_denom_big   <= w_denom_big_next;
            r_ack_prev    <= bus.coin_ack;
            r_ack_latched <= w_ack_latched_next;
        end
    end

    assign bus.coin_big   = r_coin_big;
    assign bus.coin_small = r_coin_small;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.fault      = r_fault;
    assign bus.remain     = r_remain;

endmodule
